elevator_scan_ctrl: RTL and testbench

//  Parametrised N-floor elevator controller: latches cabin and hall requests, serves them in SCAN order
//  (keep direction while requests lie ahead, then reverse), times travel and door dwell from an internal

---
 rtl/elev_pkg.sv | 13 +
 rtl/elev_req_reg.sv | 45 ++++
 rtl/elevator_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// rtl/elev_pkg.sv - FSM state and direction codes shared by the elevator controller files
package elev_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MOVE  = 2'd1;
  localparam logic [1:0] ST_DOOR  = 2'd2;

  localparam logic [1:0] DIR_IDLE = 2'd0;
  localparam logic [1:0] DIR_UP   = 2'd1;
  localparam logic [1:0] DIR_DN   = 2'd2;

  typedef logic [1:0] state_t;
  typedef logic [1:0] dir_t;
endpackage

// File: rtl/elev_req_reg.sv
// rtl/elev_req_reg.sv - latched request register with at/above/below-floor summaries
module elev_req_reg
  import elev_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] set_mask,
  input  logic [N_FLOORS-1:0] clr_mask,
  input  logic [FLOOR_W-1:0]  eval_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                at_floor,
  output logic                any_above,
  output logic                any_below
);
  logic [N_FLOORS-1:0] pend_eff;
  logic [N_FLOORS-1:0] eval_hot;
  logic [N_FLOORS-1:0] above_mask;
  logic [N_FLOORS-1:0] below_mask;

  // Decisions see this cycle's new requests too, so a press acts on the very next edge.
  assign pend_eff = pending | set_mask;

  always_comb begin
    eval_hot   = '0;
    above_mask = '0;
    below_mask = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      eval_hot[i]   = (i == int'(eval_floor));
      above_mask[i] = (i >  int'(eval_floor));
      below_mask[i] = (i <  int'(eval_floor));
    end
  end

  assign at_floor  = |(pend_eff & eval_hot);
  assign any_above = |(pend_eff & above_mask);
  assign any_below = |(pend_eff & below_mask);

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pend_eff & ~clr_mask;
  end
endmodule

// File: rtl/elevator_scan_ctrl.sv
// rtl/elevator_scan_ctrl.sv - SCAN-order elevator FSM with tick-timed travel and door dwell
// Optional emergency hold: define ELEV_ESTOP_EN to add the estop port.
module elevator_scan_ctrl
  import elev_pkg::*;
#(
  parameter int N_FLOORS     = 4,
  parameter int FLOOR_W      = $clog2(N_FLOORS),
  parameter int TICK_DIV     = 100_000_000,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_FLOORS-1:0] car_req,
  input  logic [N_FLOORS-1:0] hall_up,
  input  logic [N_FLOORS-1:0] hall_dn,
`ifdef ELEV_ESTOP_EN
  input  logic                estop,
`endif
  output logic [FLOOR_W-1:0]  floor,
  output logic [1:0]          dir,
  output logic                moving,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);
  localparam int PRE_W   = $clog2(TICK_DIV);
  localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};
  localparam logic [N_FLOORS-1:0] ONE_HOT0 = {{(N_FLOORS-1){1'b0}}, 1'b1};

  state_t              state, nstate;
  dir_t                ndir;
  logic [FLOOR_W-1:0]  nfloor, step_floor, eval_floor;
  logic [N_FLOORS-1:0] raw_req, floor_hot, eval_hot, set_mask, clr_mask;
  logic                at_floor, any_above, any_below, here_req;
  logic                go_up, go_dn, tick, step, expire, restart, entry, hold;
  logic [PRE_W-1:0]    presc;
  logic [CNT_W-1:0]    cnt;

`ifdef ELEV_ESTOP_EN
  assign hold = estop;
`else
  assign hold = 1'b0;
`endif

  assign raw_req    = car_req | (hall_up & UP_MASK) | (hall_dn & DN_MASK);
  assign floor_hot  = ONE_HOT0 << floor;
  assign step_floor = (dir == DIR_DN) ? floor - 1'b1 : floor + 1'b1;
  // While travelling, every decision is about the floor being arrived at.
  assign eval_floor = (state == ST_MOVE) ? step_floor : floor;
  assign eval_hot   = ONE_HOT0 << eval_floor;
  assign here_req   = |(raw_req & floor_hot);
  assign set_mask   = (state == ST_DOOR) ? (raw_req & ~floor_hot) : raw_req;

  assign tick   = (presc == PRE_W'(TICK_DIV - 1));
  assign step   = (state == ST_MOVE) && tick && (cnt == CNT_W'(TRAVEL_TICKS - 1));
  assign expire = (state == ST_DOOR) && tick && (cnt == CNT_W'(DOOR_TICKS - 1));

  // SCAN: keep heading while work lies ahead, otherwise reverse; idle prefers up.
  assign go_up = (dir == DIR_DN) ? (!any_below && any_above) : any_above;
  assign go_dn = (dir == DIR_DN) ? any_below : (!any_above && any_below);

  elev_req_reg #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_req (
    .clk       (clk),
    .rst       (rst),
    .set_mask  (set_mask),
    .clr_mask  (clr_mask),
    .eval_floor(eval_floor),
    .pending   (pending),
    .at_floor  (at_floor),
    .any_above (any_above),
    .any_below (any_below)
  );

  always_comb begin
    nstate   = state;
    ndir     = dir;
    nfloor   = floor;
    clr_mask = '0;
    restart  = 1'b0;
    if (!hold) begin
      case (state)
        ST_IDLE: begin
          if (at_floor) begin
            nstate   = ST_DOOR;
            clr_mask = eval_hot;
          end else if (go_up) begin
            nstate = ST_MOVE;
            ndir   = DIR_UP;
          end else if (go_dn) begin
            nstate = ST_MOVE;
            ndir   = DIR_DN;
          end else begin
            ndir = DIR_IDLE;
          end
        end
        ST_MOVE: begin
          if (step) begin
            nfloor = step_floor;
            if (at_floor) begin
              nstate   = ST_DOOR;
              clr_mask = eval_hot;
            end else if (go_up) begin
              ndir = DIR_UP;
            end else if (go_dn) begin
              ndir = DIR_DN;
            end else begin
              nstate = ST_IDLE;
              ndir   = DIR_IDLE;
            end
          end
        end
        ST_DOOR: begin
          if (here_req) begin
            restart = 1'b1;
          end else if (expire) begin
            if (go_up) begin
              nstate = ST_MOVE;
              ndir   = DIR_UP;
            end else if (go_dn) begin
              nstate = ST_MOVE;
              ndir   = DIR_DN;
            end else begin
              nstate = ST_IDLE;
              ndir   = DIR_IDLE;
            end
          end
        end
        default: nstate = ST_IDLE;
      endcase
    end
  end

  // Hopping one floor re-enters MOVE, so it restarts timing like any other entry.
  assign entry = (nstate != state) || step || restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      dir       <= DIR_IDLE;
      floor     <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      presc     <= '0;
      cnt       <= '0;
    end else begin
      state     <= nstate;
      dir       <= ndir;
      floor     <= nfloor;
      moving    <= (nstate == ST_MOVE) && !hold;
      door_open <= (nstate == ST_DOOR);
      if (!hold) begin
        if (entry) begin
          presc <= '0;
          cnt   <= '0;
        end else if (tick) begin
          presc <= '0;
          if (state != ST_IDLE) cnt <= cnt + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  floor_in_range: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, floor} < (FLOOR_W + 1)'(N_FLOORS)));
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb/tb_elevator_scan_ctrl.sv - directed vector bench for elevator_scan_ctrl (4 floors, fast tick)
module tb_elevator_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] car_req, hall_up, hall_dn;
  logic       estop;
  logic [1:0] floor, dir;
  logic       moving, door_open;
  logic [3:0] pending;
  int total = 0;
  int bad   = 0;

  elevator_scan_ctrl #(
    .N_FLOORS(4), .TICK_DIV(4), .TRAVEL_TICKS(2), .DOOR_TICKS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .car_req  (car_req),
    .hall_up  (hall_up),
    .hall_dn  (hall_dn),
`ifdef ELEV_ESTOP_EN
    .estop    (estop),
`endif
    .floor    (floor),
    .dir      (dir),
    .moving   (moving),
    .door_open(door_open),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [3:0] car, hup, hdn;
    int         n;
    logic [1:0] floor, dir;
    logic       mv, door;
    logic [3:0] pend;
  } vec_t;

  vec_t vt[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One sampled cycle with the given inputs, then quiet inputs; ends 1 time unit after the edge.
  task automatic pulse(input logic r, input logic [3:0] c, input logic [3:0] u, input logic [3:0] d);
    rst = r; car_req = c; hall_up = u; hall_dn = d;
    @(posedge clk);
    #1;
    rst = 1'b0; car_req = '0; hall_up = '0; hall_dn = '0;
  endtask

  task automatic wait_edges(input int n);
    for (int k = 0; k < n; k++) @(posedge clk);
    #1;
  endtask

  int         n_doors;
  logic       door_prev;
  logic [1:0] door_floor[2];
  logic [1:0] door_dir[2];

  initial begin
    rst = 1'b1; car_req = '0; hall_up = '0; hall_dn = '0; estop = 1'b0;
    //          r     car    hup    hdn    n   floor  dir   mv    door  pend
    vt[0]  = '{1'b1, 4'h0,  4'h0,  4'h0,  1, 2'd0,  2'd0, 1'b0, 1'b0, 4'h0};
    vt[1]  = '{1'b0, 4'h4,  4'h0,  4'h0,  0, 2'd0,  2'd1, 1'b1, 1'b0, 4'h4};
    vt[2]  = '{1'b0, 4'h0,  4'h0,  4'h0,  6, 2'd0,  2'd1, 1'b1, 1'b0, 4'h4};
    vt[3]  = '{1'b0, 4'h0,  4'h0,  4'h0,  0, 2'd1,  2'd1, 1'b1, 1'b0, 4'h4};
    vt[4]  = '{1'b0, 4'h0,  4'h0,  4'h0,  6, 2'd1,  2'd1, 1'b1, 1'b0, 4'h4};
    vt[5]  = '{1'b0, 4'h0,  4'h0,  4'h0,  0, 2'd2,  2'd1, 1'b0, 1'b1, 4'h0};
    vt[6]  = '{1'b0, 4'h0,  4'h0,  4'h0, 10, 2'd2,  2'd1, 1'b0, 1'b1, 4'h0};
    vt[7]  = '{1'b0, 4'h0,  4'h0,  4'h0,  0, 2'd2,  2'd0, 1'b0, 1'b0, 4'h0};
    vt[8]  = '{1'b0, 4'h0,  4'h8,  4'h1,  3, 2'd2,  2'd0, 1'b0, 1'b0, 4'h0};
    vt[9]  = '{1'b0, 4'h1,  4'h0,  4'h0,  3, 2'd2,  2'd2, 1'b1, 1'b0, 4'h1};
    vt[10] = '{1'b1, 4'h0,  4'h0,  4'h0,  0, 2'd0,  2'd0, 1'b0, 1'b0, 4'h0};
    vt[11] = '{1'b0, 4'h9,  4'h0,  4'h0,  0, 2'd0,  2'd0, 1'b0, 1'b1, 4'h8};
    vt[12] = '{1'b0, 4'h0,  4'h0,  4'h0, 10, 2'd0,  2'd0, 1'b0, 1'b1, 4'h8};
    vt[13] = '{1'b0, 4'h0,  4'h0,  4'h0,  0, 2'd0,  2'd1, 1'b1, 1'b0, 4'h8};
    vt[14] = '{1'b1, 4'h0,  4'h0,  4'h0,  0, 2'd0,  2'd0, 1'b0, 1'b0, 4'h0};

    @(posedge clk);
    #1;
    for (int i = 0; i < 15; i++) begin
      pulse(vt[i].r, vt[i].car, vt[i].hup, vt[i].hdn);
      if (vt[i].n > 0) wait_edges(vt[i].n);
      check($sformatf("v%0d floor", i), 32'(floor), 32'(vt[i].floor));
      check($sformatf("v%0d dir", i), 32'(dir), 32'(vt[i].dir));
      check($sformatf("v%0d moving", i), 32'(moving), 32'(vt[i].mv));
      check($sformatf("v%0d door_open", i), 32'(door_open), 32'(vt[i].door));
      check($sformatf("v%0d pending", i), 32'(pending), 32'(vt[i].pend));
    end

    // SCAN: heading up from 0 with requests at 3 and 0 serves 3, reverses, then serves 0.
    pulse(1'b0, 4'h8, 4'h0, 4'h0);
    wait_edges(2);
    pulse(1'b0, 4'h1, 4'h0, 4'h0);
    check("scan pending", 32'(pending), 32'h9);
    n_doors = 0;
    door_prev = door_open;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (door_open && !door_prev && n_doors < 2) begin
        door_floor[n_doors] = floor;
        door_dir[n_doors]   = dir;
        n_doors++;
      end
      if (!door_open && door_prev && n_doors == 2) break;
      door_prev = door_open;
    end
    check("scan door count", 32'(n_doors), 32'd2);
    if (n_doors == 2) begin
      check("scan first stop", 32'(door_floor[0]), 32'd3);
      check("scan first dir", 32'(door_dir[0]), 32'd1);
      check("scan second stop", 32'(door_floor[1]), 32'd0);
      check("scan second dir", 32'(door_dir[1]), 32'd2);
    end
    check("scan end dir", 32'(dir), 32'd0);
    check("scan end pending", 32'(pending), 32'h0);

    // Pressing the current floor 5 cycles into the dwell restarts the full 12-cycle dwell.
    pulse(1'b0, 4'h1, 4'h0, 4'h0);
    check("dwell open", 32'(door_open), 32'd1);
    check("dwell pending", 32'(pending), 32'h0);
    wait_edges(4);
    pulse(1'b0, 4'h1, 4'h0, 4'h0);
    check("dwell press pending", 32'(pending), 32'h0);
    wait_edges(11);
    check("dwell still open", 32'(door_open), 32'd1);
    wait_edges(1);
    check("dwell closed", 32'(door_open), 32'd0);
    check("dwell idle dir", 32'(dir), 32'd0);

`ifdef ELEV_ESTOP_EN
    // Ten held cycles during travel push the floor change from edge 9 to edge 19.
    pulse(1'b1, 4'h0, 4'h0, 4'h0);
    pulse(1'b0, 4'h2, 4'h0, 4'h0);
    wait_edges(1);
    estop = 1'b1;
    wait_edges(10);
    check("estop moving", 32'(moving), 32'd0);
    check("estop pending", 32'(pending), 32'h2);
    estop = 1'b0;
    wait_edges(6);
    check("estop before step", 32'(floor), 32'd0);
    wait_edges(1);
    check("estop after step", 32'(floor), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
